ram_64_arbiter: RTL

Two-requester round-robin arbiter that shares one `ram_64` (64 × 16-bit words, combinational read, write on clock edge with `load`) between two clients. It sits directly in front of the RAM. It grants at most one access per cycle, drives the RAM's `in`/`address`/`load` pins, and returns registered read data to the winning client one cycle after acceptance. An optional post-reset sequencer zero-fills the whole RAM before serving requests.

---
 rtl/ram_64_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ram_64_arbiter.sv
// Round-robin arbiter sharing one 64x16 RAM between two clients; registered read return.
// Define ARB_CLEAR_ON_RESET_EN to zero-fill the whole RAM after reset before serving.
//
// state    | meaning
// ST_CLEAR | post-reset fill, one zero write per cycle, requests ignored
// ST_SERVE | normal round-robin service of req0/req1
module ram_64_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  logic                  r_last_grant;
  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic                  w_clear;
  logic                  w_serve;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic                  w_grant0;
  logic                  w_grant1;

`ifdef ARB_CLEAR_ON_RESET_EN
  typedef enum logic {ST_CLEAR, ST_SERVE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Single pass only: leaving CLEAR after address all-ones stops the counter.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == '1) w_state_nxt = ST_SERVE;
      end
      default: w_state_nxt = ST_SERVE;
    endcase
  end

  assign w_clear    = (r_state == ST_CLEAR) && !reset;
  assign w_serve    = (r_state == ST_SERVE) && !reset;
  assign w_clr_addr = r_clr_cnt;
`else
  assign w_clear    = 1'b0;
  assign w_serve    = !reset;
  assign w_clr_addr = '0;
`endif

  // On contention the client that did not win last time gets the slot.
  assign w_grant0 = w_serve && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = w_serve && req1_valid && (!req0_valid || !r_last_grant);

  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;
  assign req0_rvalid = r_rvalid0;
  assign req1_rvalid = r_rvalid1;
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;

  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    if (w_clear) begin
      ram_address = w_clr_addr;
      ram_load    = 1'b1;
    end else if (w_grant0) begin
      ram_address = req0_addr;
      ram_in      = req0_write ? req0_wdata : '0;
      ram_load    = req0_write;
    end else if (w_grant1) begin
      ram_address = req1_addr;
      ram_in      = req1_write ? req1_wdata : '0;
      ram_load    = req1_write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      if (w_grant0)      r_last_grant <= 1'b0;
      else if (w_grant1) r_last_grant <= 1'b1;
      r_rvalid0 <= w_grant0 && !req0_write;
      r_rvalid1 <= w_grant1 && !req1_write;
      if (w_grant0 && !req0_write) r_rdata0 <= ram_out;
      if (w_grant1 && !req1_write) r_rdata1 <= ram_out;
    end
  end

endmodule
